// File: rtl/multi_rate_divider.sv
// Multi-channel programmable rate divider: each channel counts its own period and
// emits a one-cycle Tick, in periodic or one-shot mode, with start/stop/load control.
module multi_rate_divider #(
  parameter int                NUM_CH         = 4,
  parameter int                CNT_W          = 27,
  parameter int                DEFAULT_PERIOD = 50000000,
  parameter logic [NUM_CH-1:0] AUTO_START     = '0,
  parameter int                CH_W           = 2
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Start,
  input  logic [NUM_CH-1:0] Stop,
  input  logic [NUM_CH-1:0] OneShot,
  input  logic              Load,
  input  logic [CH_W-1:0]   LoadCh,
  input  logic [CNT_W-1:0]  PeriodIn,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Running,
  output logic [NUM_CH-1:0] Done
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0]  period_q  [NUM_CH];
  logic [CNT_W-1:0]  period_d  [NUM_CH];
  logic [CNT_W-1:0]  counter_q [NUM_CH];
  logic [CNT_W-1:0]  counter_d [NUM_CH];
  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] done_q,    done_d;
  logic [NUM_CH-1:0] tick_q,    tick_d;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can leave one unassigned and infer a latch.
    period_d  = period_q;
    counter_d = counter_q;
    running_d = running_q;
    oneshot_d = oneshot_q;
    done_d    = done_q;
    tick_d    = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (Stop[i]) begin
        running_d[i] = 1'b0;
      end else if (Start[i] && (period_q[i] != '0)) begin
        // Start always reloads from the period held before this edge's Load.
        counter_d[i] = period_q[i] - ONE;
        running_d[i] = 1'b1;
        oneshot_d[i] = OneShot[i];
        done_d[i]    = 1'b0;
      end else if (running_q[i]) begin
        if (counter_q[i] == '0) begin
          tick_d[i] = 1'b1;
          if (oneshot_q[i]) begin
            done_d[i]    = 1'b1;
            running_d[i] = 1'b0;
          end else if (period_q[i] == '0) begin
            // A zero period cannot be reloaded, so the finished count parks the channel.
            running_d[i] = 1'b0;
          end else begin
            counter_d[i] = period_q[i] - ONE;
          end
        end else begin
          counter_d[i] = counter_q[i] - ONE;
        end
      end

      if (Load && (int'(LoadCh) == i)) begin
        period_d[i] = PeriodIn;
      end
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      // NOTE: the period array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]  <= DEF_PERIOD;
        counter_q[i] <= DEF_PERIOD - ONE;
      end
      running_q <= AUTO_START;
      oneshot_q <= '0;
      done_q    <= '0;
      tick_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d at the same edge, independent of statement order.
      period_q  <= period_d;
      counter_q <= counter_d;
      running_q <= running_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  assign Tick    = tick_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Bench for multi_rate_divider: directed scenarios plus random strobes, compared each
// cycle against a deadline-based reference model of every channel.
module tb_multi_rate_divider;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DEFP   = 5;
  localparam int CH_W   = 3;
  localparam logic [NUM_CH-1:0] AUTO = 4'b0001;

  logic              ClockIn = 1'b0;
  logic              Reset;
  logic [NUM_CH-1:0] Start, Stop, OneShot;
  logic              Load;
  logic [CH_W-1:0]   LoadCh;
  logic [CNT_W-1:0]  PeriodIn;
  logic [NUM_CH-1:0] Tick, Running, Done;

  multi_rate_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEFP), .AUTO_START(AUTO), .CH_W(CH_W)
  ) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Stop(Stop), .OneShot(OneShot),
    .Load(Load), .LoadCh(LoadCh), .PeriodIn(PeriodIn),
    .Tick(Tick), .Running(Running), .Done(Done)
  );

  always #5 ClockIn = ~ClockIn;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  // Reference model: a running channel ticks at an absolute edge number (its deadline).
  logic [NUM_CH-1:0] m_run, m_os, m_done, m_tick;
  int                m_period   [NUM_CH];
  int                m_deadline [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [NUM_CH-1:0] st, sp, os,
                            input logic ld, input int lch, input int pin, input int e);
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_period[i]   = DEFP;
        m_deadline[i] = e + DEFP;
      end
      m_run  = AUTO;
      m_os   = '0;
      m_done = '0;
      m_tick = '0;
      return;
    end
    m_tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sp[i]) begin
        m_run[i] = 1'b0;
      end else if (st[i] && m_period[i] != 0) begin
        m_run[i]      = 1'b1;
        m_os[i]       = os[i];
        m_done[i]     = 1'b0;
        m_deadline[i] = e + m_period[i];
      end else if (m_run[i] && e == m_deadline[i]) begin
        m_tick[i] = 1'b1;
        if (m_os[i]) begin
          m_done[i] = 1'b1;
          m_run[i]  = 1'b0;
        end else if (m_period[i] == 0) begin
          m_run[i] = 1'b0;
        end else begin
          m_deadline[i] = e + m_period[i];
        end
      end
    end
    if (ld && lch < NUM_CH) m_period[lch] = pin;
  endtask

  task automatic step(input logic rst, input logic [NUM_CH-1:0] st, sp, os,
                      input logic ld, input int lch, input int pin);
    Reset    = rst;
    Start    = st;
    Stop     = sp;
    OneShot  = os;
    Load     = ld;
    LoadCh   = CH_W'(lch);
    PeriodIn = CNT_W'(pin);
    @(posedge ClockIn);
    edge_n++;
    model_step(rst, st, sp, os, ld, lch, pin, edge_n);
    #1;
    check($sformatf("tick@%0d", edge_n),    32'(Tick),    32'(m_tick));
    check($sformatf("running@%0d", edge_n), 32'(Running), 32'(m_run));
    check($sformatf("done@%0d", edge_n),    32'(Done),    32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0, 0, 0);
  endtask

  function automatic logic [NUM_CH-1:0] rnd_mask(input int one_in);
    logic [NUM_CH-1:0] m;
    for (int i = 0; i < NUM_CH; i++) m[i] = ($urandom_range(one_in - 1) == 0);
    return m;
  endfunction

  initial begin
    // Reset, then ch0 auto-runs with the default period while others stay silent.
    step(1'b1, '0, '0, '0, 1'b0, 0, 0);
    step(1'b1, '0, '0, '0, 1'b0, 0, 0);
    idle(12);

    // One-shot on ch1 with period 3.
    step(1'b0, '0, '0, '0, 1'b1, 1, 3);
    step(1'b0, 4'b0010, '0, 4'b0010, 1'b0, 0, 0);
    idle(20);

    // Shorten ch0's period mid-count; the pending tick keeps the old boundary.
    idle(2);
    step(1'b0, '0, '0, '0, 1'b1, 0, 2);
    idle(12);

    // Start+Stop on the same edge, then stop ch0 and restart it three cycles later.
    step(1'b0, 4'b0100, 4'b0100, '0, 1'b0, 0, 0);
    idle(2);
    step(1'b0, '0, 4'b0001, '0, 1'b0, 0, 0);
    idle(2);
    step(1'b0, 4'b0001, '0, '0, 1'b0, 0, 0);
    idle(8);

    // Zero period blocks Start; an out-of-range LoadCh must not alias onto ch1.
    step(1'b0, '0, '0, '0, 1'b1, 3, 0);
    step(1'b0, 4'b1000, '0, '0, 1'b0, 0, 0);
    idle(3);
    step(1'b0, '0, '0, '0, 1'b1, 5, 1);
    step(1'b0, 4'b0010, '0, '0, 1'b0, 0, 0);
    idle(10);

    // Load with Start on the same edge uses the old period first.
    step(1'b0, 4'b0100, '0, '0, 1'b1, 2, 4);
    idle(14);

    // Reset while busy with Done[1] set, then confirm defaults are back.
    step(1'b0, '0, '0, '0, 1'b1, 3, 4);
    step(1'b0, 4'b0010, '0, 4'b0010, 1'b0, 0, 0);
    idle(5);
    step(1'b0, 4'b1101, '0, '0, 1'b0, 0, 0);
    idle(2);
    step(1'b1, '0, '0, '0, 1'b0, 0, 0);
    step(1'b0, 4'b1111, '0, '0, 1'b0, 0, 0);
    idle(12);

    // Random strobes, loads and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(299) == 0), rnd_mask(9), rnd_mask(25), rnd_mask(2),
           ($urandom_range(5) == 0), $urandom_range(7), $urandom_range(6, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
